// File: rtl/cpu_pkg.sv
// Shared types for the boot-time instruction memory loader.
package cpu_pkg;

  localparam int WORD_BYTES = 4;
  localparam int WORD_BITS  = WORD_BYTES * 8;

  typedef enum logic [2:0] {
    LEN0  = 3'd0,
    LEN1  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Collects four stream bytes into one little-endian instruction word.
// word presents the register contents with the current byte already inserted,
// so the parent can capture a complete word on the edge of the 4th transfer.
module word_assembler
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic [7:0]           byte_data,
  output logic [WORD_BITS-1:0] word,
  output logic                 word_full
);

  logic [1:0]           byte_cnt_r;
  logic [WORD_BITS-1:0] word_r;
  logic [WORD_BITS-1:0] word_next_s;

  // Insert the incoming byte at the lane selected by the byte counter.
  always_comb begin
    word_next_s = word_r;
    if (shift_en) begin
      word_next_s[{byte_cnt_r, 3'b000} +: 8] = byte_data;
    end else begin
      word_next_s = word_r;
    end
  end

  assign word      = word_next_s;
  assign word_full = shift_en && (byte_cnt_r == 2'd3);

  // Byte counter (wraps after the 4th byte) and partial word storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_r <= 2'd0;
      word_r     <= '0;
    end else if (clear) begin
      byte_cnt_r <= 2'd0;
      word_r     <= '0;
    end else if (shift_en) begin
      byte_cnt_r <= byte_cnt_r + 2'd1;
      word_r     <= word_next_s;
    end else begin
      byte_cnt_r <= byte_cnt_r;
      word_r     <= word_r;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: reads a 16-bit word count and that many LE words from a byte
// stream, writes them into instruction memory, and holds the CPU in reset
// until the whole program is present.
module instr_mem_loader
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 256,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

  loader_state_t         state_r, next_state_s;
  logic [15:0]           count_r, word_idx_r;
  logic [15:0]           count_s;
  logic [WORD_BITS-1:0]  word_s;
  logic                  word_full_s;
  logic                  transfer_s, reload_s, shift_en_s, last_word_s;
  logic                  byte_ready_r, mem_we_r, cpu_hold_r, done_r, err_r;
  logic [DATA_WIDTH-1:0] mem_addr_r, mem_wdata_r;

  // byte_ready_r always mirrors the current state, so it gates transfers.
  assign transfer_s  = byte_valid && byte_ready_r;
  assign reload_s    = reload && ((state_r == DONE) || (state_r == ERR));
  assign shift_en_s  = transfer_s && (state_r == DATA);
  assign count_s     = {byte_data, count_r[7:0]};
  assign last_word_s = ((word_idx_r + 16'd1) == count_r);

  word_assembler u_word_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear     (reload_s),
    .shift_en  (shift_en_s),
    .byte_data (byte_data),
    .word      (word_s),
    .word_full (word_full_s)
  );

  // Next-state decode of the load sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      LEN0: begin
        if (transfer_s) next_state_s = LEN1;
        else            next_state_s = LEN0;
      end
      LEN1: begin
        if (!transfer_s)                       next_state_s = LEN1;
        else if (count_s == 16'd0)             next_state_s = DONE;
        else if ({1'b0, count_s} > DEPTH_LIM)  next_state_s = ERR;
        else                                   next_state_s = DATA;
      end
      DATA: begin
        if (word_full_s) next_state_s = WRITE;
        else             next_state_s = DATA;
      end
      WRITE: begin
        if (last_word_s) next_state_s = DONE;
        else             next_state_s = DATA;
      end
      DONE: begin
        if (reload) next_state_s = LEN0;
        else        next_state_s = DONE;
      end
      ERR: begin
        if (reload) next_state_s = LEN0;
        else        next_state_s = ERR;
      end
      default: next_state_s = LEN0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= LEN0;
    else      state_r <= next_state_s;
  end

  // Word count capture and written-word index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r    <= 16'd0;
      word_idx_r <= 16'd0;
    end else if (reload_s) begin
      count_r    <= 16'd0;
      word_idx_r <= 16'd0;
    end else begin
      if (transfer_s && (state_r == LEN0))      count_r[7:0]  <= byte_data;
      else if (transfer_s && (state_r == LEN1)) count_r[15:8] <= byte_data;
      else                                      count_r       <= count_r;
      if (state_r == WRITE) word_idx_r <= word_idx_r + 16'd1;
      else                  word_idx_r <= word_idx_r;
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_ready_r <= 1'b1;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= BASE_ADDR;
      mem_wdata_r  <= '0;
      cpu_hold_r   <= 1'b1;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      byte_ready_r <= (next_state_s == LEN0) || (next_state_s == LEN1) ||
                      (next_state_s == DATA);
      mem_we_r     <= (next_state_s == WRITE);
      cpu_hold_r   <= (next_state_s != DONE);
      done_r       <= (next_state_s == DONE);
      err_r        <= (next_state_s == ERR);
      if (next_state_s == WRITE) begin
        mem_addr_r  <= BASE_ADDR + (DATA_WIDTH'(word_idx_r) << 2'd2);
        mem_wdata_r <= DATA_WIDTH'(word_s);
      end else begin
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
    end
  end

  assign byte_ready = byte_ready_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule
